// File: rtl/sd_spi_phy_if.sv
// sd_spi_phy_if: controller-side word transfer bus of the SD SPI PHY
interface sd_spi_phy_if;
  logic [31:0] spi_mosi;
  logic [31:0] spi_miso;
  logic        spi_begin;
  logic        spi_busy;
  logic        spi_wide;
  logic        spi_cs;
  modport master (output spi_mosi, spi_begin, spi_wide, spi_cs, input spi_miso, spi_busy);
  modport slave  (input spi_mosi, spi_begin, spi_wide, spi_cs, output spi_miso, spi_busy);
endinterface

// File: rtl/sd_spi_phy.sv
// sd_spi_phy: mode-0 SPI shifter for SD cards, 8- or 32-bit transfers
module sd_spi_phy #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  sd_spi_phy_if.slave bus,
  output logic sd_sck,
  output logic sd_mosi,
  input  logic sd_miso,
  output logic sd_cs_n
);
  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, DONE} state_t;
  localparam logic [7:0] HALF = 8'(CLK_DIV - 1);
  state_t      state;
  logic        armed;
  logic        wide;
  logic [31:0] tx;
  logic [31:0] rx;
  logic [5:0]  bits;
  logic [7:0]  half;
  // tx holds the bits still to send after the one on sd_mosi, back-filled with ones so the line idles high after the last bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      armed        <= 1'b1;
      wide         <= 1'b0;
      tx           <= 32'h0;
      rx           <= 32'h0;
      bits         <= 6'd0;
      half         <= 8'd0;
      sd_sck       <= 1'b0;
      sd_mosi      <= 1'b1;
      sd_cs_n      <= 1'b1;
      bus.spi_busy <= 1'b0;
      bus.spi_miso <= 32'h0;
    end else begin
      sd_cs_n <= bus.spi_cs;
      case (state)
        IDLE: begin
          if (!bus.spi_begin) armed <= 1'b1;
          else if (armed) begin
            armed        <= 1'b0;
            wide         <= bus.spi_wide;
            tx           <= bus.spi_wide ? {bus.spi_mosi[30:0], 1'b1} : {bus.spi_mosi[6:0], 25'h1ffffff};
            sd_mosi      <= bus.spi_wide ? bus.spi_mosi[31] : bus.spi_mosi[7];
            bits         <= bus.spi_wide ? 6'd32 : 6'd8;
            half         <= HALF;
            bus.spi_busy <= 1'b1;
            state        <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (half != 8'd0) half <= half - 8'd1;
          else begin
            half   <= HALF;
            sd_sck <= 1'b1;
            rx     <= {rx[30:0], sd_miso};
            state  <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          if (half != 8'd0) half <= half - 8'd1;
          else begin
            half    <= HALF;
            sd_sck  <= 1'b0;
            sd_mosi <= tx[31];
            tx      <= {tx[30:0], 1'b1};
            bits    <= bits - 6'd1;
            state   <= bits == 6'd1 ? DONE : SHIFT_LO;
          end
        end
        DONE: begin
          bus.spi_miso <= wide ? rx : {24'h0, rx[7:0]};
          bus.spi_busy <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sd_spi_phy.sv
// tb_sd_spi_phy: vector table plus scoreboard bench for two divider settings
module tb_sd_spi_phy;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] t_mosi = 32'h0;
  logic t_begin = 1'b0, t_wide = 1'b0, t_cs = 1'b1;
  int t_mode = 0;
  bit sel = 1'b0;
  bit no_sb = 1'b0;
  logic cs_exp = 1'b1;

  sd_spi_phy_if b4();
  sd_spi_phy_if b1();
  assign b4.spi_mosi = t_mosi;
  assign b4.spi_begin = t_begin;
  assign b4.spi_wide = t_wide;
  assign b4.spi_cs = t_cs;
  assign b1.spi_mosi = t_mosi;
  assign b1.spi_begin = t_begin;
  assign b1.spi_wide = t_wide;
  assign b1.spi_cs = t_cs;

  logic sck4, mo4, mi4, csn4, sck1, mo1, mi1, csn1;
  assign mi4 = (t_mode == 0) ? mo4 : (t_mode == 1);
  assign mi1 = (t_mode == 0) ? mo1 : (t_mode == 1);

  sd_spi_phy #(.CLK_DIV(4)) u4 (.clk(clk), .rst(rst), .bus(b4), .sd_sck(sck4), .sd_mosi(mo4), .sd_miso(mi4), .sd_cs_n(csn4));
  sd_spi_phy #(.CLK_DIV(1)) u1 (.clk(clk), .rst(rst), .bus(b1), .sd_sck(sck1), .sd_mosi(mo1), .sd_miso(mi1), .sd_cs_n(csn1));

  logic o_sck, o_mosi, o_busy, o_csn;
  logic [31:0] o_miso;
  assign o_sck  = sel ? sck1 : sck4;
  assign o_mosi = sel ? mo1 : mo4;
  assign o_csn  = sel ? csn1 : csn4;
  assign o_busy = sel ? b1.spi_busy : b4.spi_busy;
  assign o_miso = sel ? b1.spi_miso : b4.spi_miso;

  typedef struct {logic [31:0] miso; logic [31:0] ser; int bits; int busy;} sb_t;
  typedef struct {bit sel; logic [31:0] mosi; logic wide; int mode; logic [31:0] miso; int busy;} vec_t;
  sb_t q[$];

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  int busy_cnt = 0, pulses = 0, hi_len = 0, lo_len = 0, ph_err = 0, idle_err = 0, div = 4;
  logic [31:0] ser = 32'h0;
  logic p_busy = 1'b0, p_sck = 1'b0;
  // bus monitor: serial capture, phase lengths, busy length, idle levels, scoreboard pop on completion
  always @(negedge clk) begin
    div = sel ? 1 : 4;
    if (o_busy && !p_busy) begin
      busy_cnt = 0; pulses = 0; ser = 32'h0; ph_err = 0; lo_len = 0; hi_len = 0;
    end
    if (o_busy) busy_cnt++;
    if (o_sck && !p_sck) begin
      ser = {ser[30:0], o_mosi};
      pulses++;
      if (lo_len != div) ph_err++;
      lo_len = 0;
    end
    if (!o_sck && p_sck) begin
      if (hi_len != div) ph_err++;
      hi_len = 0;
    end
    if (o_sck) hi_len++;
    else if (o_busy) lo_len++;
    if (!o_busy && (o_sck !== 1'b0 || o_mosi !== 1'b1)) idle_err++;
    if (p_busy && !o_busy && !no_sb) begin
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_done: got a completion, expected none");
      end else begin
        sb_t e;
        e = q.pop_front();
        chk("spi_miso", o_miso, e.miso);
        chk("serial_bits", ser, e.ser);
        chk("sck_pulses", pulses, e.bits);
        chk("busy_cycles", busy_cnt, e.busy);
        chk("phase_len_errs", ph_err, 0);
      end
    end
    p_busy = o_busy;
    p_sck = o_sck;
  end

  task automatic wait_busy(input logic v, input int lim, input string nm);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (o_busy !== v && k < lim);
    chk(nm, o_busy, v);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((b4.spi_busy || b1.spi_busy) && k < 600) begin
      @(negedge clk);
      k++;
    end
    chk("idle_wait", b4.spi_busy | b1.spi_busy, 0);
  endtask

  task automatic push(input logic [31:0] m, input logic w, input logic [31:0] em, input int eb);
    q.push_back('{em, w ? m : {24'h0, m[7:0]}, w ? 32 : 8, eb});
  endtask

  task automatic start(input logic [31:0] m, input logic w, input int mode, input logic [31:0] em, input int eb);
    t_mosi = m; t_wide = w; t_mode = mode;
    push(m, w, em, eb);
    t_begin = 1'b1;
    wait_busy(1'b1, 4, "accept");
    t_begin = 1'b0;
  endtask

  task automatic cs_step(input logic v, input string nm);
    t_cs = v;
    #1 chk({nm, "_hold"}, o_csn, cs_exp);
    @(negedge clk);
    chk(nm, o_csn, v);
    cs_exp = v;
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_busy"}, o_busy, 0);
    chk({nm, "_miso"}, o_miso, 0);
    chk({nm, "_sck"}, o_sck, 0);
    chk({nm, "_mosi"}, o_mosi, 1);
    chk({nm, "_csn"}, o_csn, 1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got no end of test, expected $finish");
    $fatal(1);
  end

  initial begin
    vec_t v[8];
    int k, extra;
    v[0] = '{1'b0, 32'h00000051, 1'b0, 0, 32'h00000051, 65};
    v[1] = '{1'b0, 32'hDEADBEEF, 1'b1, 1, 32'hFFFFFFFF, 257};
    v[2] = '{1'b1, 32'h000000A5, 1'b0, 0, 32'h000000A5, 17};
    v[3] = '{1'b0, 32'h123456C3, 1'b0, 0, 32'h000000C3, 65};
    v[4] = '{1'b0, 32'hCAFEF00D, 1'b1, 0, 32'hCAFEF00D, 257};
    v[5] = '{1'b1, 32'h000000FF, 1'b0, 2, 32'h00000000, 17};
    v[6] = '{1'b1, 32'h80000001, 1'b1, 0, 32'h80000001, 65};
    v[7] = '{1'b0, 32'h00000000, 1'b0, 1, 32'h000000FF, 65};
    repeat (3) @(negedge clk);
    check_reset("rst4");
    sel = 1'b1;
    #1 check_reset("rst1");
    @(negedge clk);
    rst = 1'b0;
    sel = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_idle();
      @(negedge clk);
      sel = v[i].sel;
      @(negedge clk);
      start(v[i].mosi, v[i].wide, v[i].mode, v[i].miso, v[i].busy);
      wait_idle();
    end
    sel = 1'b0;
    @(negedge clk);
    cs_step(1'b0, "cs_idle_lo");
    cs_step(1'b1, "cs_idle_hi");
    start(32'h00000096, 1'b0, 0, 32'h00000096, 65);
    t_mosi = 32'h69;
    t_wide = 1'b1;
    cs_step(1'b0, "cs_busy_lo");
    cs_step(1'b1, "cs_busy_hi");
    cs_step(1'b0, "cs_busy_lo2");
    wait_busy(1'b0, 300, "ign_done");
    t_wide = 1'b0;
    wait_idle();
    @(negedge clk);
    t_mosi = 32'h3C; t_mode = 0;
    push(32'h3C, 1'b0, 32'h3C, 65);
    t_begin = 1'b1;
    wait_busy(1'b1, 4, "held_accept");
    wait_busy(1'b0, 300, "held_done");
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_busy) extra++;
    end
    chk("held_no_retrigger", extra, 0);
    t_begin = 1'b0;
    @(negedge clk);
    push(32'h3C, 1'b0, 32'h3C, 65);
    t_begin = 1'b1;
    wait_busy(1'b1, 4, "rearm_accept");
    t_begin = 1'b0;
    wait_busy(1'b0, 300, "rearm_done");
    wait_idle();
    @(negedge clk);
    no_sb = 1'b1;
    t_mosi = 32'h0F; t_mode = 0;
    t_begin = 1'b1;
    wait_busy(1'b1, 4, "abort_accept");
    t_begin = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      #1 k++;
    end while (!(pulses == 4 && o_sck) && k < 200);
    chk("abort_reach", {31'h0, pulses == 4 && o_sck}, 1);
    rst = 1'b1;
    #1 check_reset("abort");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    no_sb = 1'b0;
    t_cs = 1'b1;
    cs_exp = 1'b1;
    t_mosi = 32'hA5;
    push(32'hA5, 1'b0, 32'hA5, 65);
    t_begin = 1'b1;
    wait_busy(1'b1, 1, "post_rst_accept");
    t_begin = 1'b0;
    wait_idle();
    @(negedge clk);
    chk("sb_drained", q.size(), 0);
    chk("idle_lines", idle_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sd_spi_phy.md
SD_SPI_PHY -- requirements
Module: sd_spi_phy

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, giving the number of clk cycles per SCK half-period (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all logic is clocked on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, an asynchronous active-high reset.
REQ-004 The block SHALL have port spi_mosi, input, 32, the transmit word; byte mode uses [7:0] only.
REQ-005 The block SHALL have port spi_miso, output, 32, the receive word of the last completed transfer.
REQ-006 The block SHALL have port spi_begin, input, 1, the transfer request.
REQ-007 The block SHALL have port spi_busy, output, 1, high while a transfer is in progress.
REQ-008 The block SHALL have port spi_wide, input, 1, transfer width select: 0 = 8 bits, 1 = 32 bits.
REQ-009 The block SHALL have port spi_cs, input, 1, the chip-select level requested by the controller (0 = selected).
REQ-010 The block SHALL have port sd_sck, output, 1, the SPI clock (mode 0, idle low).
REQ-011 The block SHALL have port sd_mosi, output, 1, serial data to the card.
REQ-012 The block SHALL have port sd_miso, input, 1, serial data from the card.
REQ-013 The block SHALL have port sd_cs_n, output, 1, the card chip select.

Function
REQ-014 The block SHALL implement the states IDLE, SHIFT_LO, SHIFT_HI and DONE.
REQ-015 In IDLE, when spi_begin=1 and the armed flag is set, the block SHALL on the same edge:
- latch spi_mosi and spi_wide;
- load the bit counter with 8 or 32;
- clear the armed flag;
- enter SHIFT_LO.
spi_busy SHALL read 1 from the next cycle.
REQ-016 The armed flag SHALL set on any cycle in IDLE with spi_begin=0, so a spi_begin held high across completion does not start a second transfer.
REQ-017 SHIFT_LO SHALL hold sd_sck=0 for CLK_DIV cycles with sd_mosi driving the current MSB of the shift register, then enter SHIFT_HI.
- Byte mode MSB is bit 7 of the latched word; wide mode MSB is bit 31.
REQ-018 On entry to SHIFT_HI the block SHALL drive sd_sck=1 and sample sd_miso into the receive shift register LSB, shifting left.
REQ-019 SHIFT_HI SHALL hold sd_sck=1 for CLK_DIV cycles, then drive sd_sck=0, shift the transmit register, and decrement the bit counter.
- Counter non-zero: the block returns to SHIFT_LO.
- Counter zero: the block enters DONE.
REQ-020 DONE SHALL last one cycle, in which the block:
- loads spi_miso ({24'h0, rx[7:0]} in byte mode, rx[31:0] in wide mode, first received bit most significant);
- drops spi_busy to 0;
- returns to IDLE.
REQ-021 Transfer latency from the accepting edge to spi_busy falling SHALL be exactly bits*2*CLK_DIV+1 cycles.
REQ-022 spi_miso SHALL change only in DONE and SHALL hold its value otherwise.
REQ-023 Outside SHIFT states, sd_mosi SHALL be 1 and sd_sck SHALL be 0.
REQ-024 sd_cs_n SHALL be spi_cs registered by one clk, independent of transfer state.
REQ-025 spi_mosi, spi_wide and spi_begin changes during a transfer SHALL be ignored.
REQ-026 The half-period counter SHALL be 8 bits wide and reload to CLK_DIV-1 at each phase change.
REQ-027 With CLK_DIV=1, sd_sck SHALL toggle every clk cycle.
REQ-028 All outputs SHALL be driven from registers.

Reset
REQ-029 While rst=1, the block SHALL force:
- state IDLE;
- sd_sck=0, sd_mosi=1, sd_cs_n=1;
- spi_busy=0, spi_miso=32'h0;
- armed flag=1;
- shift registers and counters cleared.
REQ-030 A reset asserted mid-transfer SHALL abort the transfer immediately (asynchronously), with no DONE cycle and no spi_miso update.
REQ-031 After rst deasserts, the block SHALL accept a transfer on the first clk edge with spi_begin=1.

Verification
REQ-032 Byte transfer: CLK_DIV=4, spi_mosi=32'h51, wide=0, sd_miso looped to sd_mosi, begin pulsed until busy -> sd_mosi sequence 0,1,0,1,0,0,0,1; 8 sck pulses of 4 high / 4 low cycles; busy high 65 cycles; spi_miso=32'h00000051.
REQ-033 Wide transfer: spi_mosi=32'hDEADBEEF, wide=1, sd_miso tied 1 -> 32 sck pulses; busy high 257 cycles; spi_miso=32'hFFFFFFFF.
REQ-034 Held begin: spi_begin held high through completion -> exactly one transfer; the second starts only after begin goes low for at least 1 cycle and then high.
REQ-035 Mid-transfer reset: rst pulsed after 3 sck pulses -> sd_sck=0, sd_mosi=1, sd_cs_n=1, busy=0 and spi_miso=0 in the same cycle.
REQ-036 Ignored inputs: spi_mosi and wide changed while busy -> the transmitted bits match the originally latched word.
REQ-037 Chip select: spi_cs toggled while idle and while busy -> sd_cs_n follows spi_cs with 1-cycle delay.
REQ-038 Minimum divider: CLK_DIV=1, byte 8'hA5 loopback -> busy high 17 cycles; spi_miso=32'h000000A5.
